// File: rtl/ram_mfc_responder_pkg.sv
// Shared definitions for the MFA/MFC memory responder: SPARC op3 codes,
// FSM state encoding, access-size classification and default timing.
package ram_mfc_responder_pkg;

  // SPARC op3 encodings understood by the responder.
  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;

  localparam int DEFAULT_WAIT_STATES = 2;
  // Wide enough for the full 0..15 wait-state range.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_e;

endpackage

// File: rtl/ram_mfc_responder_mem_lane_align.sv
// Combinational byte-lane steering for a big-endian 32-bit word memory:
// extracts and sign/zero-extends load data, replicates store data onto the
// addressed lanes and flags misaligned halfword/word accesses.
module mem_lane_align
  import ram_mfc_responder_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  offs_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic        misaligned_o,
  output logic [31:0] load_data_o,
  output logic [31:0] store_data_o,
  output logic [3:0]  store_be_o
);

  size_e       size;
  logic        is_load;
  logic        is_store;
  logic        is_signed;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Classify the op into direction, width and signedness.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    size      = SZ_NONE;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    case (op_i)
      OP_LD:   begin is_load  = 1'b1; size = SZ_WORD; end
      OP_LDUB: begin is_load  = 1'b1; size = SZ_BYTE; end
      OP_LDUH: begin is_load  = 1'b1; size = SZ_HALF; end
      OP_LDSB: begin is_load  = 1'b1; size = SZ_BYTE; is_signed = 1'b1; end
      OP_LDSH: begin is_load  = 1'b1; size = SZ_HALF; is_signed = 1'b1; end
      OP_ST:   begin is_store = 1'b1; size = SZ_WORD; end
      OP_STB:  begin is_store = 1'b1; size = SZ_BYTE; end
      OP_STH:  begin is_store = 1'b1; size = SZ_HALF; end
      default: ;
    endcase
  end

  // Big-endian: byte offset 0 lives in bits 31:24, so lane = ~offset.
  assign byte_sel = rword_i[{~offs_i, 3'b000} +: 8];
  assign half_sel = offs_i[1] ? rword_i[15:0] : rword_i[31:16];

  assign misaligned_o = ((size == SZ_HALF) && offs_i[0]) ||
                        ((size == SZ_WORD) && (offs_i != 2'b00));

  // Build the load result and the store lane data/enables; a misaligned
  // access produces neither.
  always_comb begin
    load_data_o  = '0;
    store_data_o = '0;
    store_be_o   = '0;
    if (!misaligned_o) begin
      if (is_load) begin
        case (size)
          SZ_BYTE: load_data_o = is_signed ? {{24{byte_sel[7]}}, byte_sel}
                                           : {24'b0, byte_sel};
          SZ_HALF: load_data_o = is_signed ? {{16{half_sel[15]}}, half_sel}
                                           : {16'b0, half_sel};
          SZ_WORD: load_data_o = rword_i;
          default: ;
        endcase
      end
      if (is_store) begin
        case (size)
          SZ_BYTE: begin
            store_data_o = {4{wdata_i[7:0]}};
            store_be_o   = 4'b1000 >> offs_i;
          end
          SZ_HALF: begin
            store_data_o = {2{wdata_i[15:0]}};
            store_be_o   = offs_i[1] ? 4'b0011 : 4'b1100;
          end
          SZ_WORD: begin
            store_data_o = wdata_i;
            store_be_o   = 4'b1111;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ram_mfc_responder.sv
// Byte-addressed RAM behind a four-phase MFA/MFC handshake. A request is
// captured in IDLE, aged WAIT_STATES cycles, performed in one edge, then
// the result is held in DONE until the requester drops MFA.
module ram_mfc_responder
  import ram_mfc_responder_pkg::*;
#(
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES,
  parameter int ADDR_W      = 9
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              MFA,
  input  logic [5:0]        OP,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MFC,
  output logic              MAE,
  output logic              Busy
);

  localparam int WORDS = 2 ** (ADDR_W - 2);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              mfc_q, mfc_d;
  logic              mae_q, mae_d;
  logic [31:0]       dout_q, dout_d;
  logic              cap_en;
  logic              access;

  logic [31:0]       mem [WORDS];
  logic [ADDR_W-3:0] widx;
  logic [31:0]       rword;
  logic              misaligned;
  logic [31:0]       load_data;
  logic [31:0]       store_data;
  logic [3:0]        store_be;

  // Word index drops the byte offset; its width makes the wrap implicit.
  assign widx  = addr_q[ADDR_W-1:2];
  assign rword = mem[widx];

  mem_lane_align u_lane (
    .op_i         (op_q),
    .offs_i       (addr_q[1:0]),
    .wdata_i      (wdata_q),
    .rword_i      (rword),
    .misaligned_o (misaligned),
    .load_data_o  (load_data),
    .store_data_o (store_data),
    .store_be_o   (store_be)
  );

  // State, wait counter, captured request and registered outputs.
  always_ff @(posedge Clk or negedge Clr) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!Clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mfc_q   <= 1'b0;
      mae_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mfc_q   <= mfc_d;
      mae_q   <= mae_d;
      dout_q  <= dout_d;
      if (cap_en) begin
        op_q    <= OP;
        addr_q  <= Address;
        wdata_q <= DataIn;
      end
    end
  end

  // Next-state: wait out the counter, then hold until MFA is released.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (MFA) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  if (!MFA) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-state datapath: capture, count down, perform the access, release.
  always_comb begin
    cnt_d  = cnt_q;
    mfc_d  = mfc_q;
    mae_d  = mae_q;
    dout_d = dout_q;
    cap_en = 1'b0;
    access = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MFA) begin
          cap_en = 1'b1;
          cnt_d  = CNT_W'(WAIT_STATES);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          access = 1'b1;
          mfc_d  = 1'b1;
          mae_d  = misaligned;
          dout_d = load_data;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (!MFA) begin
          mfc_d = 1'b0;
          mae_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Store commit on the completing edge, only the enabled byte lanes.
  always_ff @(posedge Clk) begin
    // NOTE: the array has no reset; contents survive Clr by design, and a
    // reset mid-transaction returns to IDLE so access never fires.
    if (access) begin
      for (int b = 0; b < 4; b++) begin
        if (store_be[b]) mem[widx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

  assign DataOut = dout_q;
  assign MFC     = mfc_q;
  assign MAE     = mae_q;
  assign Busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_mfc_responder.sv
// Bench: two responders (WAIT_STATES 0 and 2) share one request stream and
// are compared every cycle against a byte-array transaction model.
module tb_ram_mfc_responder;
  import ram_mfc_responder_pkg::*;

  logic        Clk;
  logic        Clr;
  logic        MFA;
  logic [5:0]  OP;
  logic [8:0]  Address;
  logic [31:0] DataIn;
  logic [31:0] dout [2];
  logic [1:0]  mfc;
  logic [1:0]  mae;
  logic [1:0]  busy;

  int tests = 0;
  int fails = 0;

  // Index 0: zero wait states, index 1: two wait states.
  ram_mfc_responder #(.WAIT_STATES(0), .ADDR_W(9)) dut0 (
    .Clk(Clk), .Clr(Clr), .MFA(MFA), .OP(OP), .Address(Address),
    .DataIn(DataIn), .DataOut(dout[0]), .MFC(mfc[0]), .MAE(mae[0]),
    .Busy(busy[0])
  );

  ram_mfc_responder #(.WAIT_STATES(2), .ADDR_W(9)) dut2 (
    .Clk(Clk), .Clr(Clr), .MFA(MFA), .OP(OP), .Address(Address),
    .DataIn(DataIn), .DataOut(dout[1]), .MFC(mfc[1]), .MAE(mae[1]),
    .Busy(busy[1])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mm [2][512];
  int          cyc = 0;
  logic [1:0]  m_busy, m_mfc, m_mae;
  logic [31:0] m_dout [2];
  int          m_due  [2];
  logic [5:0]  m_op   [2];
  logic [8:0]  m_addr [2];
  logic [31:0] m_data [2];

  // Functional effect of one transaction on a byte-addressed big-endian RAM.
  function automatic void model_access(input int d, input logic [5:0] op,
      input logic [8:0] a, input logic [31:0] wd,
      output logic [31:0] r, output logic e);
    int i;
    i = int'(a);
    r = 32'h0;
    e = 1'b0;
    case (op)
      OP_LD:   if (a[1:0] != 0) e = 1'b1;
               else r = {mm[d][i], mm[d][i+1], mm[d][i+2], mm[d][i+3]};
      OP_LDUB: r = {24'h0, mm[d][i]};
      OP_LDSB: r = {{24{mm[d][i][7]}}, mm[d][i]};
      OP_LDUH: if (a[0]) e = 1'b1; else r = {16'h0, mm[d][i], mm[d][i+1]};
      OP_LDSH: if (a[0]) e = 1'b1;
               else r = {{16{mm[d][i][7]}}, mm[d][i], mm[d][i+1]};
      OP_ST:   if (a[1:0] != 0) e = 1'b1;
               else begin
                 mm[d][i] = wd[31:24]; mm[d][i+1] = wd[23:16];
                 mm[d][i+2] = wd[15:8]; mm[d][i+3] = wd[7:0];
               end
      OP_STB:  mm[d][i] = wd[7:0];
      OP_STH:  if (a[0]) e = 1'b1;
               else begin mm[d][i] = wd[15:8]; mm[d][i+1] = wd[7:0]; end
      default: ;
    endcase
  endfunction

  // Edge-numbered timeline: accepted at edge k, completes at k+W+1,
  // released at the first later edge that sees MFA low.
  always @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      m_busy <= '0;
      m_mfc  <= '0;
      m_mae  <= '0;
      for (int d = 0; d < 2; d++) m_dout[d] <= '0;
    end else begin
      int now;
      now = cyc + 1;
      cyc <= now;
      for (int d = 0; d < 2; d++) begin
        logic [31:0] r;
        logic        e;
        if (!m_busy[d]) begin
          if (MFA) begin
            m_busy[d] <= 1'b1;
            m_due[d]  <= now + (d == 0 ? 0 : 2) + 1;
            m_op[d]   <= OP;
            m_addr[d] <= Address;
            m_data[d] <= DataIn;
          end
        end else if (!m_mfc[d]) begin
          if (now == m_due[d]) begin
            model_access(d, m_op[d], m_addr[d], m_data[d], r, e);
            m_mfc[d]  <= 1'b1;
            m_mae[d]  <= e;
            m_dout[d] <= r;
          end
        end else if (!MFA) begin
          m_busy[d] <= 1'b0;
          m_mfc[d]  <= 1'b0;
          m_mae[d]  <= 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge Clk) begin
    for (int d = 0; d < 2; d++) begin
      check($sformatf("mfc[%0d]", d),  {31'b0, mfc[d]},  {31'b0, m_mfc[d]});
      check($sformatf("mae[%0d]", d),  {31'b0, mae[d]},  {31'b0, m_mae[d]});
      check($sformatf("busy[%0d]", d), {31'b0, busy[d]}, {31'b0, m_busy[d]});
      if (m_mfc[d]) check($sformatf("dout[%0d]", d), dout[d], m_dout[d]);
    end
  end

  // ---------------- stimulus ----------------
  // One handshake; returns the slow DUT's result and both latencies in edges.
  task automatic txn(input logic [5:0] op, input logic [8:0] addr,
      input logic [31:0] data, input int hold, input bit drop_early,
      output logic [31:0] r, output logic e, output int lat2, output int lat0);
    int n;
    bit done;
    n = -1; lat2 = -1; lat0 = -1; done = 1'b0;
    r = '0; e = 1'b0;
    @(negedge Clk);
    MFA = 1'b1; OP = op; Address = addr; DataIn = data;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge Clk); #1;
      n++;
      if (n == 0) begin
        OP = 6'($urandom); Address = 9'($urandom); DataIn = $urandom;
        if (drop_early) MFA = 1'b0;
      end
      if (mfc[0] && lat0 < 0) lat0 = n;
      if (mfc[1] && lat2 < 0) begin lat2 = n; r = dout[1]; e = mae[1]; end
      done = (lat0 >= 0) && (lat2 >= 0);
    end
    check("mfc_seen", {31'b0, done}, 32'd1);
    if (!drop_early) begin
      repeat (hold) @(posedge Clk);
      @(negedge Clk);
      MFA = 1'b0;
    end
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge Clk); #1;
      done = (busy == 2'b00);
    end
    check("idle_seen", {31'b0, done}, 32'd1);
  endtask

  logic [5:0] ops [10] = '{OP_LD, OP_LDUB, OP_LDUH, OP_ST, OP_STB, OP_STH,
                           OP_LDSB, OP_LDSH, 6'h3F, 6'h07};

  initial begin
    logic [31:0] r;
    logic        e;
    int          l2, l0;
    Clr = 1'b0; MFA = 1'b0; OP = '0; Address = '0; DataIn = '0;
    repeat (2) @(negedge Clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_dout", dout[d], 32'h0);
      check("rst_flags", {29'b0, mfc[d], mae[d], busy[d]}, 32'h0);
    end
    Clr = 1'b1;

    // Give every word a known value.
    for (int i = 0; i < 128; i++) txn(OP_ST, 9'(i * 4), $urandom, 0, 1'b0, r, e, l2, l0);

    // Word store then load, with latency.
    txn(OP_ST, 9'h010, 32'hDEADBEEF, 0, 1'b0, r, e, l2, l0);
    check("st_dout", r, 32'h0);
    txn(OP_LD, 9'h010, 32'h0, 0, 1'b0, r, e, l2, l0);
    check("ld_word", r, 32'hDEADBEEF);
    check("lat_ws2", 32'(l2), 32'd3);
    check("lat_ws0", 32'(l0), 32'd1);

    // Signed byte.
    txn(OP_STB, 9'h013, 32'h00000080, 0, 1'b0, r, e, l2, l0);
    txn(OP_LDSB, 9'h013, 32'h0, 0, 1'b0, r, e, l2, l0);
    check("ldsb", r, 32'hFFFFFF80);
    txn(OP_LDUB, 9'h013, 32'h0, 0, 1'b0, r, e, l2, l0);
    check("ldub", r, 32'h00000080);
    txn(OP_LD, 9'h010, 32'h0, 0, 1'b0, r, e, l2, l0);
    check("ld_merged", r, 32'hDEADBE80);

    // Misaligned halfword.
    txn(OP_ST, 9'h020, 32'h11223344, 0, 1'b0, r, e, l2, l0);
    txn(OP_LDUH, 9'h021, 32'h0, 0, 1'b0, r, e, l2, l0);
    check("mis_ld_mae", {31'b0, e}, 32'd1);
    check("mis_ld_dout", r, 32'h0);
    txn(OP_STH, 9'h021, 32'h0000AAAA, 0, 1'b0, r, e, l2, l0);
    check("mis_st_mae", {31'b0, e}, 32'd1);
    txn(OP_LD, 9'h020, 32'h0, 0, 1'b0, r, e, l2, l0);
    check("mis_st_nowrite", r, 32'h11223344);
    txn(OP_LDSH, 9'h022, 32'h0, 0, 1'b0, r, e, l2, l0);
    check("ldsh", r, 32'h00003344);

    // Unsupported op completes cleanly.
    txn(6'h3F, 9'h010, 32'hFFFFFFFF, 0, 1'b0, r, e, l2, l0);
    check("bad_op", {r[30:0], e}, 32'h0);

    // Long hold after MFC, then release.
    txn(OP_LD, 9'h010, 32'h0, 5, 1'b0, r, e, l2, l0);
    check("hold_dout", r, 32'hDEADBE80);
    check("hold_release", {30'b0, mfc[1], busy[1]}, 32'h0);

    // MFA dropped during WAIT still completes.
    txn(OP_LDUH, 9'h012, 32'h0, 0, 1'b1, r, e, l2, l0);
    check("drop_dout", r, 32'h0000BE80);

    // Reset abort of an in-flight store.
    txn(OP_ST, 9'h040, 32'hCAFEF00D, 0, 1'b0, r, e, l2, l0);
    @(negedge Clk);
    MFA = 1'b1; OP = OP_ST; Address = 9'h040; DataIn = 32'h12345678;
    @(posedge Clk); #2;
    Clr = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("abort_dout", dout[d], 32'h0);
      check("abort_flags", {29'b0, mfc[d], mae[d], busy[d]}, 32'h0);
    end
    MFA = 1'b0;
    @(negedge Clk);
    Clr = 1'b1;
    txn(OP_LD, 9'h040, 32'h0, 0, 1'b0, r, e, l2, l0);
    check("abort_nowrite", r, 32'hCAFEF00D);

    // Top word of memory.
    txn(OP_ST, 9'h1FC, 32'h0BADF00D, 0, 1'b0, r, e, l2, l0);
    txn(OP_LD, 9'h1FC, 32'h0, 0, 1'b0, r, e, l2, l0);
    check("top_word", r, 32'h0BADF00D);
    check("top_lat_ws0", 32'(l0), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 250; i++) begin
      txn(ops[$urandom_range(9)], 9'($urandom), $urandom, $urandom_range(3),
          ($urandom_range(7) == 0), r, e, l2, l0);
    end

    repeat (3) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
